mul_feeder: RTL and testbench
=============================

MUL_FEEDER -- requirements
Module: mul_feeder

Interface
Parameters:
REQ-001 SHALL provide parameter W, default 16: operand and product width.
REQ-002 SHALL provide parameter DEPTH, default 2: operand-pair FIFO depth; legal values 2 and 4.
REQ-003 SHALL provide parameter TMO, default 255: maximum WAIT cycles before abort; legal range 1..65535.
Ports (name, direction, width, meaning):
REQ-004 SHALL provide clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL provide rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL provide in_valid, input, 1: upstream offers an operand pair.
REQ-007 SHALL provide in_ready, output, 1: FIFO accepts a pair this cycle.
REQ-008 SHALL provide in_a, input, W: multiplicand.
REQ-009 SHALL provide in_b, input, W: multiplier operand.
REQ-010 SHALL provide mul_start, output, 1: start strobe to the multiplier controller.
REQ-011 SHALL provide mul_data, output, W: shared operand bus to the multiplier datapath.
REQ-012 SHALL provide mul_done, input, 1: multiplier completion level.
REQ-013 SHALL provide mul_prod, input, W: multiplier product register value.
REQ-014 SHALL provide out_valid, output, 1: result available.
REQ-015 SHALL provide out_ready, input, 1: downstream accepts the result.
REQ-016 SHALL provide out_prod, output, W: captured product.
REQ-017 SHALL provide out_err, output, 1: result is a timeout abort.

Function
REQ-018 SHALL hold operand pairs in a DEPTH-entry FIFO; push when in_valid && in_ready.
REQ-019 SHALL drive in_ready = !full, with no same-cycle bypass when full, even if a pop occurs.
REQ-020 SHALL use states IDLE, LDA, LDB, WAIT, OUT.
REQ-021 SHALL transition IDLE->LDA when the FIFO is non-empty, popping the head pair into internal registers a_r and b_r on that edge.
REQ-022 SHALL, in LDA (exactly 1 cycle), drive mul_data = a_r and mul_start = 1, then go to LDB.
REQ-023 SHALL, in LDB (exactly 1 cycle), drive mul_data = b_r and mul_start = 0, then go to WAIT.
REQ-024 SHALL, in WAIT, keep mul_data = b_r and increment a wait counter each cycle starting from 0 on WAIT entry.
REQ-025 SHALL, in WAIT with mul_done = 1 sampled, capture out_prod <= mul_prod and out_err <= 0, then go to OUT.
REQ-026 SHALL, in WAIT when the counter reaches TMO with mul_done = 0, set out_prod <= 0 and out_err <= 1, then go to OUT; mul_done takes priority if both occur in the same cycle.
REQ-027 SHALL, in OUT, assert out_valid and hold out_prod and out_err stable until out_ready = 1, then go to IDLE.
REQ-028 SHALL drive mul_data = 0 in IDLE and OUT; mul_start SHALL be 1 only in LDA.
REQ-029 SHALL allow FIFO pushes in every state, including while OUT is stalled.
REQ-030 SHALL wrap FIFO pointers modulo DEPTH and track occupancy 0..DEPTH with a count.
REQ-031 SHALL pass zero operands through unchanged with no special-casing.
REQ-032 SHALL use a 16-bit wait counter that never wraps, because it stops at TMO.
REQ-033 SHALL have a minimum per-pair latency of 4 cycles from pop to out_valid when mul_done = 1 on the first WAIT cycle.

Reset
REQ-034 SHALL, on rst_n low and asynchronously, set state = IDLE, FIFO empty, wait counter = 0, a_r = b_r = 0, out_prod = 0, out_err = 0, out_valid = 0, mul_start = 0, mul_data = 0, and in_ready = 1 once rst_n is high.
REQ-035 SHALL abandon any in-flight operation and discard all queued pairs on reset mid-operation, with no result emitted.

Verification
REQ-036 SHALL pass: push (a=3, b=4), mul_done high 6 cycles after LDB with mul_prod = 12 -> mul_data shows 3 then 4, a single mul_start pulse, out_prod = 12, out_err = 0.
REQ-037 SHALL pass: DEPTH = 2, three back-to-back pushes with out_ready = 0 -> third push blocked (in_ready = 0) until the first pair pops, then accepted; results arrive in order.
REQ-038 SHALL pass: TMO = 5, mul_done held 0 -> out_err = 1, out_prod = 0 exactly 5 cycles after WAIT entry.
REQ-039 SHALL pass: mul_done rises in the same cycle the counter reaches TMO -> out_err = 0, product captured.
REQ-040 SHALL pass: rst_n low during WAIT with 1 pair queued -> all outputs at reset values immediately, FIFO empty, no out_valid after release.
REQ-041 SHALL pass: out_ready = 0 for 10 cycles in OUT -> out_prod and out_err stable, no new LDA until the handshake completes.

Source files
------------

// File: rtl/mul_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mul_feeder: queues operand pairs and sequences them onto a shared bus    |
// | for a multi-cycle multiplier, with a bounded wait and timeout abort.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mul_feeder #(
  parameter int W     = 16,
  parameter int DEPTH = 2,
  parameter int TMO   = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         mul_start,
  output logic [W-1:0] mul_data,
  input  logic         mul_done,
  input  logic [W-1:0] mul_prod,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_prod,
  output logic         out_err
);

  localparam int                c_ptr_w    = $clog2(DEPTH);
  localparam int                c_cnt_w    = $clog2(DEPTH + 1);
  localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(DEPTH - 1);
  localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [15:0]        c_tmo_last = 16'(TMO - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LDA  = 3'd1,
    LDB  = 3'd2,
    WAIT = 3'd3,
    OUT  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [W-1:0]       r_fifo_a [DEPTH];
  logic [W-1:0]       r_fifo_b [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [15:0]        r_wait_cnt;
  logic [W-1:0]       r_out_prod;
  logic               r_out_err;

  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_tmo_hit;

  // in_ready looks only at the registered count, so a pop never frees a slot
  // for a push in the same cycle.
  assign in_ready  = (r_count != c_cnt_full);
  assign w_empty   = (r_count == '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = (r_state == IDLE) && !w_empty;
  assign w_tmo_hit = (r_wait_cnt == c_tmo_last);
  assign out_prod  = r_out_prod;
  assign out_err   = r_out_err;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_a[r_wr_ptr] <= in_a;
      r_fifo_b[r_wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    mul_start   = 1'b0;
    mul_data    = '0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) w_state_nxt = LDA;
      end
      LDA: begin
        mul_start   = 1'b1;
        mul_data    = r_a;
        w_state_nxt = LDB;
      end
      LDB: begin
        mul_data    = r_b;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        mul_data = r_b;
        if (mul_done || w_tmo_hit) w_state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The wait counter leaves WAIT no later than TMO, so 16 bits never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_wait_cnt <= '0;
      r_out_prod <= '0;
      r_out_err  <= 1'b0;
    end else begin
      if (w_pop) begin
        r_a <= r_fifo_a[r_rd_ptr];
        r_b <= r_fifo_b[r_rd_ptr];
      end
      if (r_state == LDB) begin
        r_wait_cnt <= '0;
      end else if (r_state == WAIT) begin
        r_wait_cnt <= r_wait_cnt + 16'd1;
        if (mul_done) begin
          r_out_prod <= mul_prod;
          r_out_err  <= 1'b0;
        end else if (w_tmo_hit) begin
          r_out_prod <= '0;
          r_out_err  <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_feeder.sv
`default_nettype none
// Directed testbench for mul_feeder: one default instance driven by a small
// multiplier model, one TMO=5 instance driven by hand for timeout cases.
module tb_mul_feeder;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;

  logic         in_valid0, in_ready0, mul_start0, mul_done0, out_valid0, out_ready0, out_err0;
  logic [W-1:0] in_a0, in_b0, mul_data0, mul_prod0, out_prod0;
  logic         in_valid1, in_ready1, mul_start1, mul_done1, out_valid1, out_ready1, out_err1;
  logic [W-1:0] in_a1, in_b1, mul_data1, mul_prod1, out_prod1;

  int n_checks = 0;
  int n_errors = 0;

  int           mdl_phase;
  int           mdl_cnt;
  int           mdl_lat;
  logic [W-1:0] mdl_a, mdl_b;

  always #5 clk = ~clk;

  mul_feeder #(.W(W), .DEPTH(2), .TMO(255)) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid0),
    .in_ready  (in_ready0),
    .in_a      (in_a0),
    .in_b      (in_b0),
    .mul_start (mul_start0),
    .mul_data  (mul_data0),
    .mul_done  (mul_done0),
    .mul_prod  (mul_prod0),
    .out_valid (out_valid0),
    .out_ready (out_ready0),
    .out_prod  (out_prod0),
    .out_err   (out_err0)
  );

  mul_feeder #(.W(W), .DEPTH(2), .TMO(5)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_a      (in_a1),
    .in_b      (in_b1),
    .mul_start (mul_start1),
    .mul_data  (mul_data1),
    .mul_done  (mul_done1),
    .mul_prod  (mul_prod1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_prod  (out_prod1),
    .out_err   (out_err1)
  );

  // Multiplier model for u_dut0: latches A then B off the bus, raises done
  // mdl_lat cycles after B and holds it until the next start.
  always @(negedge clk) begin
    if (!rst_n) begin
      mdl_phase <= 0;
      mdl_cnt   <= 0;
      mul_done0 <= 1'b0;
      mul_prod0 <= '0;
    end else begin
      case (mdl_phase)
        0: if (mul_start0) begin
          mdl_a     <= mul_data0;
          mul_done0 <= 1'b0;
          mdl_phase <= 1;
        end
        1: begin
          mdl_b     <= mul_data0;
          mdl_cnt   <= 0;
          mdl_phase <= 2;
        end
        default: begin
          if (mdl_cnt == mdl_lat - 1) begin
            mul_done0 <= 1'b1;
            mul_prod0 <= W'(mdl_a * mdl_b);
            mdl_phase <= 0;
          end else begin
            mdl_cnt <= mdl_cnt + 1;
          end
        end
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_ov0(input string tag);
    int i = 0;
    while (out_valid0 !== 1'b1 && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_out_valid"}, out_valid0, 1);
  endtask

  task automatic wait_start0(input string tag);
    int i = 0;
    while (mul_start0 !== 1'b1 && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_mul_start"}, mul_start0, 1);
  endtask

  task automatic accept0();
    out_ready0 = 1'b1;
    @(negedge clk);
    out_ready0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_ord [3];
    int          n_starts;
    logic        seen;
    exp_ord[0] = 21; exp_ord[1] = 54; exp_ord[2] = 143;

    in_valid0 = 0; in_a0 = 0; in_b0 = 0; out_ready0 = 0; mdl_lat = 6;
    in_valid1 = 0; in_a1 = 0; in_b1 = 0; out_ready1 = 0; mul_done1 = 0; mul_prod1 = 0;
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_mul_start", mul_start0, 0);
    chk("rst_mul_data", mul_data0, 0);
    chk("rst_out_prod", out_prod0, 0);
    chk("rst_out_err", out_err0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready0, 1);

    // Basic 3 x 4, done 6 cycles after LDB
    in_valid0 = 1; in_a0 = 3; in_b0 = 4;
    @(negedge clk); in_valid0 = 0;
    @(negedge clk);
    chk("lda_start", mul_start0, 1);
    chk("lda_data", mul_data0, 3);
    @(negedge clk);
    chk("ldb_start", mul_start0, 0);
    chk("ldb_data", mul_data0, 4);
    n_starts = 0;
    repeat (6) begin
      @(negedge clk);
      if (mul_start0) n_starts++;
      chk("wait_data", mul_data0, 4);
    end
    @(negedge clk);
    chk("a34_valid", out_valid0, 1);
    chk("a34_prod", out_prod0, 12);
    chk("a34_err", out_err0, 0);
    chk("a34_extra_starts", n_starts, 0);
    chk("out_data_zero", mul_data0, 0);
    accept0();
    chk("a34_released", out_valid0, 0);

    // Full FIFO blocks the third push while an earlier result stalls in OUT
    mdl_lat = 3;
    in_valid0 = 1; in_a0 = 2; in_b0 = 5;
    @(negedge clk); in_valid0 = 0;
    wait_ov0("p0");
    chk("p0_prod", out_prod0, 10);
    in_valid0 = 1; in_a0 = 3; in_b0 = 7;
    @(negedge clk);
    chk("push2_ready", in_ready0, 1);
    in_a0 = 6; in_b0 = 9;
    @(negedge clk);
    in_a0 = 11; in_b0 = 13;
    repeat (3) begin
      chk("full_blocked", in_ready0, 0);
      @(negedge clk);
    end
    chk("stall_p0_prod", out_prod0, 10);
    out_ready0 = 1;
    @(negedge clk); out_ready0 = 0;
    chk("no_bypass", in_ready0, 0);
    @(negedge clk);
    chk("after_pop_ready", in_ready0, 1);
    @(negedge clk); in_valid0 = 0;
    for (int k = 0; k < 3; k++) begin
      wait_ov0("ord");
      chk("order_prod", out_prod0, exp_ord[k]);
      accept0();
    end

    // Ten-cycle stall in OUT with a pair waiting behind it
    mdl_lat = 2;
    in_valid0 = 1; in_a0 = 100; in_b0 = 200;
    @(negedge clk); in_valid0 = 0;
    wait_ov0("s1");
    in_valid0 = 1; in_a0 = 9; in_b0 = 9;
    @(negedge clk); in_valid0 = 0;
    repeat (10) begin
      chk("stall_valid", out_valid0, 1);
      chk("stall_prod", out_prod0, 20000);
      chk("stall_err", out_err0, 0);
      chk("stall_no_lda", mul_start0, 0);
      @(negedge clk);
    end
    accept0();
    wait_ov0("s2");
    chk("s2_prod", out_prod0, 81);
    accept0();

    // TMO=5 instance: done arrives on the last counted cycle and wins
    in_valid1 = 1; in_a1 = 5; in_b1 = 6;
    @(negedge clk); in_valid1 = 0;
    @(negedge clk);
    chk("t1_lda", mul_start1, 1);
    repeat (6) @(negedge clk);
    chk("t1_pre_valid", out_valid1, 0);
    mul_done1 = 1; mul_prod1 = 30;
    @(negedge clk); mul_done1 = 0;
    chk("t1_valid", out_valid1, 1);
    chk("t1_err", out_err1, 0);
    chk("t1_prod", out_prod1, 30);
    out_ready1 = 1;
    @(negedge clk); out_ready1 = 0;

    // TMO=5 instance: no done, abort exactly 5 cycles after WAIT entry
    mul_prod1 = 16'hBEEF;
    in_valid1 = 1; in_a1 = 3; in_b1 = 3;
    @(negedge clk); in_valid1 = 0;
    @(negedge clk);
    chk("t2_lda", mul_start1, 1);
    repeat (6) @(negedge clk);
    chk("t2_early", out_valid1, 0);
    @(negedge clk);
    chk("t2_valid", out_valid1, 1);
    chk("t2_err", out_err1, 1);
    chk("t2_prod", out_prod1, 0);
    out_ready1 = 1;
    @(negedge clk); out_ready1 = 0;

    // Reset during WAIT with one pair queued
    mdl_lat = 50;
    in_valid0 = 1; in_a0 = 4; in_b0 = 4;
    @(negedge clk); in_valid0 = 0;
    wait_start0("r");
    in_valid0 = 1; in_a0 = 5; in_b0 = 5;
    @(negedge clk); in_valid0 = 0;
    @(negedge clk); @(negedge clk);
    chk("pre_rst_data", mul_data0, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_data", mul_data0, 0);
    chk("mid_rst_start", mul_start0, 0);
    chk("mid_rst_valid", out_valid0, 0);
    chk("mid_rst_prod", out_prod0, 0);
    chk("mid_rst_err", out_err0, 0);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid0 || mul_start0) seen = 1'b1;
    end
    chk("post_rst_idle", seen, 0);
    chk("post_rst_ready", in_ready0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
